alu_op_sequencer: RTL and testbench

Sequential front end for the 4-bit ALU datapath. Collects operand A, operand B and an opcode from the board switches, one value per key pulse. Drives them to the ALU as registered, stable operands and waits a fixed latency. Captures the ALU result and holds it for display until the next command. Sits between the switch/key input logic and the ALU, on the initiator side of the ALU operand/result interface.

---
 rtl/alu_op_sequencer.sv | 109 ++++++++++
 tb/tb_alu_op_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Operand/opcode entry sequencer for the 4-bit ALU: captures A, B, op per key pulse, waits LAT cycles, holds result.
// Optional build macro ALU_SEQ_CHAIN_EN: an entry while a result is held chains it as operand A of the next command.
module alu_op_sequencer #(
    parameter int W   = 4,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sw,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_res,
    output logic [W-1:0] res_out,
    output logic         res_valid,
    output logic         busy,
    output logic         overrun,
    output logic [7:0]   op_count
);

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_OP,
        S_EXEC,
        S_DONE
    } state_t;

    localparam logic [3:0] LAT_CNT = 4'(LAT);

    state_t     state;
    logic [3:0] cnt;
    logic       accept;

    assign accept = key_valid & key_ready;

    // key_ready and busy are registered alongside the state so they track it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_A;
            cnt       <= '0;
            key_ready <= 1'b1;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_out   <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            op_count  <= '0;
        end else begin
            if (key_valid && !key_ready)
                overrun <= 1'b1;

            case (state)
                S_A: begin
                    if (accept) begin
                        alu_a <= sw;
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (accept) begin
                        alu_b <= sw;
                        state <= S_OP;
                    end
                end
                S_OP: begin
                    if (accept) begin
                        alu_op    <= sw[2:0];
                        cnt       <= LAT_CNT;
                        state     <= S_EXEC;
                        key_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_EXEC: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        res_out   <= alu_res;
                        res_valid <= 1'b1;
                        op_count  <= op_count + 8'd1;
                        state     <= S_DONE;
                        key_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (accept) begin
`ifdef ALU_SEQ_CHAIN_EN
                        alu_a     <= res_out;
                        alu_b     <= sw;
                        res_valid <= 1'b0;
                        state     <= S_OP;
`else
                        alu_a     <= sw;
                        res_valid <= 1'b0;
                        state     <= S_B;
`endif
                    end
                end
                default: state <= S_A;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer; u1 runs LAT=1, u2 runs LAT=4, both share stimulus.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] sw = '0;
    logic       key_valid = 1'b0;

    logic       kr1, rv1, busy1, ovr1, kr2, rv2, busy2, ovr2;
    logic [3:0] a1, b1, res1, ro1, a2, b2, res2, ro2;
    logic [2:0] op1, op2;
    logic [7:0] cnt1, cnt2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return ~a;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return a ^ b;
            3'd7: return (a == b) ? 4'd1 : 4'd0;
            default: return 4'd0;
        endcase
    endfunction

    assign res1 = alu_f(a1, b1, op1);
    assign res2 = alu_f(a2, b2, op2);

    alu_op_sequencer #(.W(4), .LAT(1)) u1 (
        .clk(clk), .rst(rst), .sw(sw), .key_valid(key_valid), .key_ready(kr1),
        .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_res(res1), .res_out(ro1),
        .res_valid(rv1), .busy(busy1), .overrun(ovr1), .op_count(cnt1)
    );

    alu_op_sequencer #(.W(4), .LAT(4)) u2 (
        .clk(clk), .rst(rst), .sw(sw), .key_valid(key_valid), .key_ready(kr2),
        .alu_a(a2), .alu_b(b2), .alu_op(op2), .alu_res(res2), .res_out(ro2),
        .res_valid(rv2), .busy(busy2), .overrun(ovr2), .op_count(cnt2)
    );

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic pulse(input logic [3:0] v);
        sw = v; key_valid = 1'b1;
        @(negedge clk); key_valid = 1'b0;
    endtask

    task automatic issue(input bit sel, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        logic in_done;
        in_done = sel ? rv2 : rv1;
`ifdef ALU_SEQ_CHAIN_EN
        if (!in_done) pulse(a);
`else
        if (in_done || !in_done) pulse(a);
`endif
        pulse(b);
        pulse(op);
    endtask

    task automatic wait_res(input bit sel);
        for (int i = 0; i < 40 && !(sel ? rv2 : rv1); i++) @(negedge clk);
        if (!(sel ? rv2 : rv1)) begin
            total++;
            $display("FAIL wait_res: res_valid not seen within 40 cycles (dut %0d)", sel);
        end
    endtask

    task automatic cmd(input bit sel, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        issue(sel, a, b, op);
        wait_res(sel);
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b1; key_valid = 1'b1; sw = 4'd9;
        @(negedge clk); rst = 1'b0; key_valid = 1'b0;
        total++; if (a1 !== 4'd0) $display("FAIL rst_alu_a: got %0d want 0", a1); else passed++;
        total++; if ({b1, op1, ro1, rv1, busy1, ovr1} !== '0) $display("FAIL rst_outs: got %h want 0", {b1, op1, ro1, rv1, busy1, ovr1}); else passed++;
        total++; if (cnt1 !== 8'd0) $display("FAIL rst_op_count: got %0d want 0", cnt1); else passed++;
        total++; if (kr1 !== 1'b1) $display("FAIL rst_key_ready: got %b want 1", kr1); else passed++;
    endtask

    task automatic test_basic();
        do_reset();
        pulse(4'd3);
        total++; if (a1 !== 4'd3) $display("FAIL basic_a: got %0d want 3", a1); else passed++;
        pulse(4'd5);
        total++; if (b1 !== 4'd5) $display("FAIL basic_b: got %0d want 5", b1); else passed++;
        pulse(4'd0);
        total++; if (op1 !== 3'd0 || busy1 !== 1'b1 || kr1 !== 1'b0) $display("FAIL basic_exec: got op=%0d busy=%b kr=%b want 0 1 0", op1, busy1, kr1); else passed++;
        total++; if (rv1 !== 1'b0) $display("FAIL basic_rv_early: got %b want 0", rv1); else passed++;
        @(negedge clk);
        total++; if (ro1 !== 4'd8 || rv1 !== 1'b1) $display("FAIL basic_res: got %0d/%b want 8/1", ro1, rv1); else passed++;
        total++; if (cnt1 !== 8'd1 || busy1 !== 1'b0 || kr1 !== 1'b1) $display("FAIL basic_done: got cnt=%0d busy=%b kr=%b want 1 0 1", cnt1, busy1, kr1); else passed++;
    endtask

    task automatic test_latency();
        do_reset();
        pulse(4'd9); pulse(4'd4); pulse(4'd1);
        for (int i = 0; i < 4; i++) begin
            total++; if (busy2 !== 1'b1 || kr2 !== 1'b0 || rv2 !== 1'b0) $display("FAIL lat_exec%0d: got busy=%b kr=%b rv=%b want 1 0 0", i, busy2, kr2, rv2); else passed++;
            @(negedge clk);
        end
        total++; if (busy2 !== 1'b0 || rv2 !== 1'b1 || ro2 !== 4'd5) $display("FAIL lat_done: got busy=%b rv=%b res=%0d want 0 1 5", busy2, rv2, ro2); else passed++;
    endtask

    task automatic test_overrun();
        logic [3:0] exp;
        do_reset();
        pulse(4'd9); pulse(4'd4); pulse(4'd1);
        pulse(4'd15);
        total++; if (ovr2 !== 1'b1) $display("FAIL ovr_set: got %b want 1", ovr2); else passed++;
        total++; if (a2 !== 4'd9 || b2 !== 4'd4 || op2 !== 3'd1 || busy2 !== 1'b1) $display("FAIL ovr_hold: got a=%0d b=%0d op=%0d busy=%b want 9 4 1 1", a2, b2, op2, busy2); else passed++;
        wait_res(1'b1);
        total++; if (ro2 !== 4'd5) $display("FAIL ovr_res: got %0d want 5", ro2); else passed++;
`ifdef ALU_SEQ_CHAIN_EN
        pulse(4'd2); pulse(4'd0); exp = 4'd7;
`else
        pulse(4'd2); pulse(4'd1); pulse(4'd0); exp = 4'd3;
`endif
        wait_res(1'b1);
        total++; if (ro2 !== exp || ovr2 !== 1'b1) $display("FAIL ovr_sticky: got res=%0d ovr=%b want %0d 1", ro2, ovr2, exp); else passed++;
    endtask

    task automatic test_exit_edge_drop();
        do_reset();
        pulse(4'd3); pulse(4'd5); pulse(4'd0);
        pulse(4'd7);
        total++; if (ovr1 !== 1'b1 || rv1 !== 1'b1 || ro1 !== 4'd8 || a1 !== 4'd3) $display("FAIL exit_drop: got ovr=%b rv=%b res=%0d a=%0d want 1 1 8 3", ovr1, rv1, ro1, a1); else passed++;
    endtask

    task automatic test_done_entry();
        do_reset();
        cmd(1'b0, 4'd3, 4'd5, 4'd0);
        pulse(4'd7);
`ifdef ALU_SEQ_CHAIN_EN
        total++; if (a1 !== 4'd8 || b1 !== 4'd7 || rv1 !== 1'b0) $display("FAIL chain_entry: got a=%0d b=%0d rv=%b want 8 7 0", a1, b1, rv1); else passed++;
        pulse(4'd0);
        total++; if (busy1 !== 1'b1 || op1 !== 3'd0) $display("FAIL chain_op: got busy=%b op=%0d want 1 0", busy1, op1); else passed++;
        @(negedge clk);
        total++; if (ro1 !== 4'd15 || rv1 !== 1'b1) $display("FAIL chain_res: got %0d/%b want 15/1", ro1, rv1); else passed++;
`else
        total++; if (a1 !== 4'd7 || rv1 !== 1'b0 || busy1 !== 1'b0) $display("FAIL done_entry: got a=%0d rv=%b busy=%b want 7 0 0", a1, rv1, busy1); else passed++;
        pulse(4'd2);
        total++; if (b1 !== 4'd2 || a1 !== 4'd7 || busy1 !== 1'b0) $display("FAIL done_to_b: got a=%0d b=%0d busy=%b want 7 2 0", a1, b1, busy1); else passed++;
`endif
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk); sw = 4'd6; key_valid = 1'b1;
        @(negedge clk); sw = 4'd2;
        total++; if (a1 !== 4'd6) $display("FAIL b2b_a: got %0d want 6", a1); else passed++;
        @(negedge clk); sw = 4'hE;
        total++; if (b1 !== 4'd2) $display("FAIL b2b_b: got %0d want 2", b1); else passed++;
        @(negedge clk); key_valid = 1'b0;
        total++; if (op1 !== 3'b110 || busy1 !== 1'b1) $display("FAIL b2b_op: got op=%0d busy=%b want 6 1", op1, busy1); else passed++;
        @(negedge clk);
        total++; if (ro1 !== 4'd0 || rv1 !== 1'b1) $display("FAIL b2b_res: got %0d/%b want 0/1", ro1, rv1); else passed++;
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        cmd(1'b1, 4'd9, 4'd4, 4'd1);
        cmd(1'b1, 4'd2, 4'd3, 4'd4);
        total++; if (cnt2 !== 8'd2) $display("FAIL mid_pre_count: got %0d want 2", cnt2); else passed++;
        issue(1'b1, 4'd1, 4'd1, 4'd0);
        total++; if (busy2 !== 1'b1) $display("FAIL mid_in_exec: got %b want 1", busy2); else passed++;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        total++; if ({a2, b2, op2, ro2, rv2, busy2, ovr2, cnt2} !== '0 || kr2 !== 1'b1) $display("FAIL mid_reset: got %h kr=%b want 0 1", {a2, b2, op2, ro2, rv2, busy2, ovr2, cnt2}, kr2); else passed++;
        repeat (6) @(negedge clk);
        total++; if (rv2 !== 1'b0 || cnt2 !== 8'd0 || busy2 !== 1'b0) $display("FAIL mid_no_capture: got rv=%b cnt=%0d busy=%b want 0 0 0", rv2, cnt2, busy2); else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 255; i++) cmd(1'b0, 4'd1, 4'd1, 4'd0);
        total++; if (cnt1 !== 8'd255) $display("FAIL wrap_255: got %0d want 255", cnt1); else passed++;
        cmd(1'b0, 4'd1, 4'd1, 4'd0);
        total++; if (cnt1 !== 8'd0 || rv1 !== 1'b1) $display("FAIL wrap_0: got %0d/%b want 0/1", cnt1, rv1); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_overrun();
        test_exit_edge_drop();
        test_done_entry();
        test_back_to_back();
        test_reset_mid_exec();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
